// File: rtl/riscv_defines.sv
// Shared definitions for the EX-stage string-op unit: operator codes, FSM states
// and the ASCII constants used by the byte translator.
package riscv_defines;

    localparam int unsigned STR_OP_WIDTH = 3;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } str_ops_state_e;

    // Letter range bounds and case offset
    localparam logic [7:0] ASCII_A_UP     = 8'h41;
    localparam logic [7:0] ASCII_N_UP     = 8'h4E;
    localparam logic [7:0] ASCII_Z_UP     = 8'h5A;
    localparam logic [7:0] ASCII_A_LO     = 8'h61;
    localparam logic [7:0] ASCII_N_LO     = 8'h6E;
    localparam logic [7:0] ASCII_Z_LO     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;
    localparam logic [7:0] ASCII_ROT      = 8'd13;

    // Leet source letters (lower case) and their digit replacements
    localparam logic [7:0] ASCII_E_LO = 8'h65;
    localparam logic [7:0] ASCII_I_LO = 8'h69;
    localparam logic [7:0] ASCII_O_LO = 8'h6F;
    localparam logic [7:0] ASCII_S_LO = 8'h73;
    localparam logic [7:0] ASCII_T_LO = 8'h74;
    localparam logic [7:0] ASCII_DIG0 = 8'h30;
    localparam logic [7:0] ASCII_DIG1 = 8'h31;
    localparam logic [7:0] ASCII_DIG3 = 8'h33;
    localparam logic [7:0] ASCII_DIG4 = 8'h34;
    localparam logic [7:0] ASCII_DIG5 = 8'h35;
    localparam logic [7:0] ASCII_DIG7 = 8'h37;

endpackage

// File: rtl/riscv_str_byte_xlate.sv
// Combinational single-byte translator (UPPER/LOWER/LEET, plus ROT13 when
// RISCV_STR_OPS_ROT13_EN is defined). Unknown operators pass the byte through.
module riscv_str_byte_xlate
    import riscv_defines::*;
(
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [7:0]              byte_i,
    output logic [7:0]              byte_c_o
);

    logic       is_upper;
    logic       is_lower;
    logic [7:0] folded;

    assign is_upper = (byte_i >= ASCII_A_UP) && (byte_i <= ASCII_Z_UP);
    assign is_lower = (byte_i >= ASCII_A_LO) && (byte_i <= ASCII_Z_LO);
    // Lower-case view of a letter so leet matching ignores case
    assign folded   = byte_i | ASCII_CASE_BIT;

    always_comb begin
        byte_c_o = byte_i;
        case (operator_i)
            STR_OP_UPPER: if (is_lower) byte_c_o = byte_i - ASCII_CASE_BIT;
            STR_OP_LOWER: if (is_upper) byte_c_o = byte_i + ASCII_CASE_BIT;
            STR_OP_LEET: begin
                if (is_upper || is_lower) begin
                    case (folded)
                        ASCII_A_LO: byte_c_o = ASCII_DIG4;
                        ASCII_E_LO: byte_c_o = ASCII_DIG3;
                        ASCII_I_LO: byte_c_o = ASCII_DIG1;
                        ASCII_O_LO: byte_c_o = ASCII_DIG0;
                        ASCII_S_LO: byte_c_o = ASCII_DIG5;
                        ASCII_T_LO: byte_c_o = ASCII_DIG7;
                        default:    byte_c_o = byte_i;
                    endcase
                end
            end
`ifdef RISCV_STR_OPS_ROT13_EN
            STR_OP_ROT13: begin
                if (is_lower) begin
                    byte_c_o = (byte_i < ASCII_N_LO) ? byte_i + ASCII_ROT : byte_i - ASCII_ROT;
                end else if (is_upper) begin
                    byte_c_o = (byte_i < ASCII_N_UP) ? byte_i + ASCII_ROT : byte_i - ASCII_ROT;
                end
            end
`endif
            default: byte_c_o = byte_i;
        endcase
    end

endmodule

// File: rtl/riscv_str_ops_mc.sv
// Multi-cycle string-op unit for EX: translates LANES bytes per cycle and holds
// the result until EX accepts it. ROT13 support via RISCV_STR_OPS_ROT13_EN.
module riscv_str_ops_mc
    import riscv_defines::*;
#(
    parameter int unsigned NUM_BYTES = 4,
    parameter int unsigned LANES     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [8*NUM_BYTES-1:0]  operand_i,
    output logic [8*NUM_BYTES-1:0]  result_o,
    output logic                    ready_o,
    output logic                    busy_o,
    input  logic                    ex_ready_i
);

    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - LANES);

    str_ops_state_e                state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [STR_OP_WIDTH-1:0]       op_q, op_d;
    logic [NUM_BYTES-1:0][7:0]     operand_q, operand_d;
    logic [NUM_BYTES-1:0][7:0]     result_q, result_d;
    logic [LANES-1:0][7:0]         lane_in;
    logic [LANES-1:0][7:0]         lane_out;

    // One translator per lane, fed from the current byte window
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = operand_q[idx_q + IDX_W'(l)];
        riscv_str_byte_xlate u_xlate (
            .operator_i (op_q),
            .byte_i     (lane_in[l]),
            .byte_c_o   (lane_out[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            op_q      <= '0;
            operand_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        operand_d = operand_q;
        result_d  = result_q;
        ready_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = !enable_i;
                if (enable_i) begin
                    state_d   = BUSY;
                    op_d      = operator_i;
                    operand_d = operand_i;
                    idx_d     = '0;
                    result_d  = '0;
                end
            end
            BUSY: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    result_d[idx_q + IDX_W'(l)] = lane_out[l];
                end
                idx_d = idx_q + IDX_STEP;
                if (idx_q == IDX_LAST) state_d = DONE;
            end
            DONE: begin
                ready_o = 1'b1;
                if (ex_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o   = (state_q == BUSY);
    assign result_o = (state_q == DONE) ? result_q : '0;

endmodule
